// File: rtl/reg_file_sb.sv
// Register file with two write ports, two combinational read ports, an optional
// same-cycle write bypass and a per-register pending-write (busy) scoreboard.
// Register 0 is hardwired to zero and is never busy.

// One storage entry: the data word plus its busy bit.
module reg_file_sb_cell #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int IDX    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_wa,
    output logic [DATA_W-1:0] q,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] ME = ADDR_W'(IDX);

    logic hit0, hit1, set_b;

    assign hit0  = we0 && (wa0 == ME);
    assign hit1  = we1 && (wa1 == ME);
    assign set_b = iss_en && (iss_wa == ME);

    // Data word: port 1 (MEM writeback) has priority over port 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (hit1)
            q <= wd1;
        else if (hit0)
            q <= wd0;
    end

    // Busy bit: a new issue beats a same-cycle writeback so a WAW pair stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= 1'b0;
        else if (set_b)
            busy <= 1'b1;
        else if (hit0 || hit1)
            busy <= 1'b0;
    end
endmodule

// One read port: stored value, optionally replaced by data being written this cycle.
module reg_file_sb_rport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0]                     ra,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    regs,
    input  logic [(2**ADDR_W)-1:0]                busy,
    input  logic                                  we0,
    input  logic [ADDR_W-1:0]                     wa0,
    input  logic [DATA_W-1:0]                     wd0,
    input  logic                                  we1,
    input  logic [ADDR_W-1:0]                     wa1,
    input  logic [DATA_W-1:0]                     wd1,
    input  logic                                  iss_en,
    input  logic [ADDR_W-1:0]                     iss_wa,
    output logic [DATA_W-1:0]                     rd,
    output logic                                  rd_busy
);
    logic nz, hit0, hit1, iss_hit;

    assign nz      = (ra != '0);
    assign hit0    = nz && we0 && (wa0 == ra);
    assign hit1    = nz && we1 && (wa1 == ra);
    assign iss_hit = nz && iss_en && (iss_wa == ra);

    // Forward port 1 first, then port 0; a forwarded operand is no longer pending
    // unless a new producer is being issued to the same register right now.
    always_comb begin
        rd      = regs[ra];
        rd_busy = busy[ra];
        if (BYPASS != 0) begin
            if (hit1)
                rd = wd1;
            else if (hit0)
                rd = wd0;
            if ((hit0 || hit1) && !iss_hit)
                rd_busy = 1'b0;
        end
    end
endmodule

module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd1_busy,
    output logic              rd2_busy,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_wa,
    output logic              any_busy
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NRD   = 2;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             busy;
    logic [NRD-1:0][ADDR_W-1:0]   ra;
    logic [NRD-1:0][DATA_W-1:0]   rd;
    logic [NRD-1:0]               rbusy;

    assign regs[0] = '0;
    assign busy[0] = 1'b0;

    genvar r, p;
    generate
        for (r = 1; r < DEPTH; r++) begin : g_reg
            reg_file_sb_cell #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IDX(r)) u_cell (
                .clk(clk), .rst(rst),
                .we0(we0), .wa0(wa0), .wd0(wd0),
                .we1(we1), .wa1(wa1), .wd1(wd1),
                .iss_en(iss_en), .iss_wa(iss_wa),
                .q(regs[r]), .busy(busy[r])
            );
        end

        for (p = 0; p < NRD; p++) begin : g_rd
            reg_file_sb_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rport (
                .ra(ra[p]), .regs(regs), .busy(busy),
                .we0(we0), .wa0(wa0), .wd0(wd0),
                .we1(we1), .wa1(wa1), .wd1(wd1),
                .iss_en(iss_en), .iss_wa(iss_wa),
                .rd(rd[p]), .rd_busy(rbusy[p])
            );
        end
    endgenerate

    assign ra[0]    = ra1;
    assign ra[1]    = ra2;
    assign rd1      = rd[0];
    assign rd2      = rd[1];
    assign rd1_busy = rbusy[0];
    assign rd2_busy = rbusy[1];

    // Drain indicator straight off the registered busy bits.
    assign any_busy = |busy;
endmodule
